// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - SRAM arbiter constants, request struct and round-robin pick helper
package sram_arb_pkg;

   localparam int SRAM_ADDR_W = 11;
   localparam int SRAM_DATA_W = 64;
   localparam int RR_MAX_REQ  = 8;

   typedef struct packed {
      logic                   we;
      logic [SRAM_ADDR_W-1:0] addr;
      logic [SRAM_DATA_W-1:0] wdata;
   } sram_req_t;

   typedef struct packed {
      logic [2:0] idx;
      logic       found;
   } rr_pick_t;

   // Walk offsets from the highest down so the smallest offset from ptr with a
   // pending request is the last one written, i.e. the winner.
   function automatic rr_pick_t rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
      rr_pick_t   res;
      logic [2:0] j;
      res = '0;
      for (int i = RR_MAX_REQ - 1; i >= 0; i--) begin
         if (i < n) begin
            j = 3'((int'(ptr) + i) % n);
            if (req[j]) begin
               res.idx   = j;
               res.found = 1'b1;
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/sram_rr_arbiter_if.sv
// rtl/sram_rr_arbiter_if.sv - requester-side bus of the SRAM round-robin arbiter
interface sram_rr_arbiter_if
   import sram_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = SRAM_ADDR_W,
   parameter int DATA_W  = SRAM_DATA_W
);
   logic [NUM_REQ-1:0]        req_i;
   logic [NUM_REQ-1:0]        we_i;
   logic [NUM_REQ*ADDR_W-1:0] addr_i;
   logic [NUM_REQ*DATA_W-1:0] wdata_i;
   logic [NUM_REQ-1:0]        gnt_o;
   logic [NUM_REQ-1:0]        rvalid_o;
   logic [DATA_W-1:0]         rdata_o;

   modport master (
      output req_i, we_i, addr_i, wdata_i,
      input  gnt_o, rvalid_o, rdata_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i,
      output gnt_o, rvalid_o, rdata_o
   );
endinterface

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational rotate-and-leading-one round-robin search
module rr_priority_pick
   import sram_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          found
);
   rr_pick_t res;

   // First requester at or after ptr, wrapping, wins
   always_comb begin
      res   = rr_pick(8'(req), 3'(ptr), N);
      idx   = IW'(res.idx);
      found = res.found;
   end
endmodule

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - round-robin arbiter for one single-port SRAM; SRAM_ARB_RDATA_REG_EN adds a read output stage
module sram_rr_arbiter
   import sram_arb_pkg::*;
#(
   parameter int  NUM_REQ = 4,
   parameter int  ADDR_W  = SRAM_ADDR_W,
   parameter int  DATA_W  = SRAM_DATA_W,
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   sram_rr_arbiter_if.slave  bus,
   output logic              sram_ceb_o,
   output logic              sram_web_o,
   output logic [ADDR_W-1:0] sram_a_o,
   output logic [DATA_W-1:0] sram_d_o,
   input  logic [DATA_W-1:0] sram_q_i
);
   logic [IDX_W-1:0]   ptr_q;
   logic [IDX_W-1:0]   win_idx;
   logic               win_found;
   logic               grant;
   logic               rd_grant;
   logic               tag_vld_q;
   logic [IDX_W-1:0]   tag_idx_q;
   logic [NUM_REQ-1:0] rvalid_c;

   rr_priority_pick #(
      .N  (NUM_REQ),
      .IW (IDX_W)
   ) u_pick (
      .req   (bus.req_i),
      .ptr   (ptr_q),
      .idx   (win_idx),
      .found (win_found)
   );

   // Grant and SRAM drive follow the winner; everything idles while in reset
   always_comb begin
      grant      = win_found & rst_ni;
      rd_grant   = grant & ~bus.we_i[win_idx];
      bus.gnt_o  = '0;
      if (grant) begin
         bus.gnt_o[win_idx] = 1'b1;
      end
      sram_ceb_o = ~grant;
      sram_web_o = ~(grant & bus.we_i[win_idx]);
      sram_a_o   = bus.addr_i[win_idx*ADDR_W +: ADDR_W];
      sram_d_o   = bus.wdata_i[win_idx*DATA_W +: DATA_W];
   end

   // Pointer moves just past the winner; tag records who owns next cycle's Q
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q     <= '0;
         tag_vld_q <= 1'b0;
         tag_idx_q <= '0;
      end else begin
         tag_vld_q <= rd_grant;
         if (grant) begin
            ptr_q <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
         end
         if (rd_grant) begin
            tag_idx_q <= win_idx;
         end
      end
   end

   // One-hot read-valid steered to the requester that issued the read
   always_comb begin
      rvalid_c = '0;
      if (tag_vld_q) begin
         rvalid_c[tag_idx_q] = 1'b1;
      end
   end

`ifdef SRAM_ARB_RDATA_REG_EN
   logic [NUM_REQ-1:0] rvalid_q;
   logic [DATA_W-1:0]  rdata_q;

   // Extra output stage: read latency becomes two cycles, throughput unchanged
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= rvalid_c;
         rdata_q  <= sram_q_i;
      end
   end

   assign bus.rvalid_o = rvalid_q;
   assign bus.rdata_o  = rdata_q;
`else
   assign bus.rvalid_o = rvalid_c;
   assign bus.rdata_o  = sram_q_i;
`endif
endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb/tb_sram_rr_arbiter.sv - scoreboard bench for the SRAM round-robin arbiter
module tb_sram_rr_arbiter;
   localparam int NR = 4;
   localparam int AW = 11;
   localparam int DW = 64;
`ifdef SRAM_ARB_RDATA_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      int            cyc;
      int            idx;
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] d;
   } gexp_t;

   typedef struct {
      int            cyc;
      int            idx;
      logic [DW-1:0] data;
   } rexp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          sram_ceb;
   logic          sram_web;
   logic [AW-1:0] sram_a;
   logic [DW-1:0] sram_d;
   logic [DW-1:0] sram_q;

   int    cyc = 0;
   int    n_chk = 0;
   int    n_fail = 0;
   gexp_t gnt_q[$];
   rexp_t rd_q[$];
   gexp_t ge;
   rexp_t re;

   logic [DW-1:0] mem [0:2047];
   bit            wr_flag [0:2047];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   sram_rr_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

   sram_rr_arbiter #(
      .NUM_REQ (NR),
      .ADDR_W  (AW),
      .DATA_W  (DW)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .bus        (bus),
      .sram_ceb_o (sram_ceb),
      .sram_web_o (sram_web),
      .sram_a_o   (sram_a),
      .sram_d_o   (sram_d),
      .sram_q_i   (sram_q)
   );

   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      if (a == 11'h05A) return 64'hDEAD_BEEF_0123_4567;
      return 64'h1111_0000_0000_0000 | DW'(a);
   endfunction

   // Single-port SRAM model: Q valid the cycle after the read edge, held otherwise
   always @(posedge clk) begin
      if (!sram_ceb) begin
         if (!sram_web) begin
            mem[sram_a]     <= sram_d;
            wr_flag[sram_a] <= 1'b1;
         end else begin
            sram_q <= wr_flag[sram_a] ? mem[sram_a] : init_val(sram_a);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   // Monitor: compare the DUT against queued expectations each cycle
   always @(negedge clk) begin
      if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
         ge = gnt_q.pop_front();
         chk("gnt", 64'(bus.gnt_o), 64'(1) << ge.idx);
         chk("ceb", 64'(sram_ceb), 64'(0));
         chk("web", 64'(sram_web), 64'(!ge.we));
         chk("addr", 64'(sram_a), 64'(ge.addr));
         if (ge.we) chk("wdata", sram_d, ge.d);
      end else begin
         chk("gnt_idle", 64'(bus.gnt_o), 64'(0));
         chk("ceb_idle", 64'(sram_ceb), 64'(1));
         chk("web_idle", 64'(sram_web), 64'(1));
      end
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
         re = rd_q.pop_front();
         chk("rvalid", 64'(bus.rvalid_o), 64'(1) << re.idx);
         chk("rdata", bus.rdata_o, re.data);
      end else begin
         chk("rvalid_idle", 64'(bus.rvalid_o), 64'(0));
      end
   end

   task automatic set_rd(input int k, input logic [AW-1:0] a);
      bus.we_i[k]              = 1'b0;
      bus.addr_i[k*AW +: AW]   = a;
   endtask

   task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.we_i[k]              = 1'b1;
      bus.addr_i[k*AW +: AW]   = a;
      bus.wdata_i[k*DW +: DW]  = d;
   endtask

   task automatic push_exp(input int k, input logic [DW-1:0] rd_exp, input bit expect_rd);
      if (k >= 0) begin
         gnt_q.push_back('{cyc: cyc, idx: k, we: bus.we_i[k],
                           addr: bus.addr_i[k*AW +: AW], d: bus.wdata_i[k*DW +: DW]});
         if (!bus.we_i[k] && expect_rd) rd_q.push_back('{cyc: cyc + LAT, idx: k, data: rd_exp});
      end
   endtask

   task automatic step(input int k, input logic [DW-1:0] rd_exp);
      push_exp(k, rd_exp, 1'b1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.req_i   = '0;
      bus.we_i    = '0;
      bus.addr_i  = '0;
      bus.wdata_i = '0;
      @(posedge clk); #1;
      bus.req_i = '1;
      @(posedge clk); #1;
      bus.req_i = '0;
      rst_n     = 1'b1;

      set_rd(1, 11'h05A);
      bus.req_i = 4'b0010;
      step(1, 64'hDEAD_BEEF_0123_4567);
      bus.req_i = '0;
      repeat (3) step(-1, '0);

      set_wr(0, 11'h7FF, 64'hA5A5_A5A5_A5A5_A5A5);
      bus.req_i = 4'b0001;
      step(0, '0);
      set_rd(0, 11'h7FF);
      step(0, 64'hA5A5_A5A5_A5A5_A5A5);
      bus.req_i = '0;
      repeat (3) step(-1, '0);

      set_rd(3, 11'h0FF);
      bus.req_i = 4'b1000;
      step(3, 64'h1111_0000_0000_00FF);
      for (int k = 0; k < NR; k++) set_rd(k, AW'(11'h100 + k));
      bus.req_i = 4'b1111;
      step(0, 64'h1111_0000_0000_0100);
      step(1, 64'h1111_0000_0000_0101);
      step(2, 64'h1111_0000_0000_0102);
      step(3, 64'h1111_0000_0000_0103);
      step(0, 64'h1111_0000_0000_0100);
      step(1, 64'h1111_0000_0000_0101);
      step(2, 64'h1111_0000_0000_0102);
      step(3, 64'h1111_0000_0000_0103);
      bus.req_i = '0;
      repeat (3) step(-1, '0);

      set_rd(1, 11'h020);
      bus.req_i = 4'b0010;
      step(1, 64'h1111_0000_0000_0020);
      set_rd(0, 11'h030);
      set_rd(1, 11'h031);
      bus.req_i = 4'b0011;
      step(0, 64'h1111_0000_0000_0030);
      step(1, 64'h1111_0000_0000_0031);
      set_wr(2, 11'h123, 64'h0123_4567_89AB_CDEF);
      bus.req_i = 4'b0100;
      step(2, '0);
      set_rd(2, 11'h123);
      step(2, 64'h0123_4567_89AB_CDEF);
      bus.req_i = '0;
      repeat (3) step(-1, '0);

      set_rd(3, 11'h200);
      bus.req_i = 4'b1000;
      push_exp(3, '0, 1'b0);
      @(negedge clk); #2;
      rst_n     = 1'b0;
      bus.req_i = '1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < NR; k++) set_rd(k, AW'(11'h100 + k));
      step(0, 64'h1111_0000_0000_0100);
      step(1, 64'h1111_0000_0000_0101);
      bus.req_i = '0;
      repeat (3) step(-1, '0);

      chk("gnt_q_drained", 64'(gnt_q.size()), 64'(0));
      chk("rd_q_drained", 64'(rd_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
      $fatal(1, "watchdog");
   end
endmodule
